// File: rtl/lamp_pkg.sv
// Shared constants for the lamp-bus decoder: lamp-state codes, record layout and FSM states.
package lamp_pkg;

  localparam logic [1:0] LAMP_DARK  = 2'b00;
  localparam logic [1:0] LAMP_ON    = 2'b01;
  localparam logic [1:0] LAMP_FLICK = 2'b10;

  // Record layout: {duration, state vector}, state vector in the low bits.
  localparam int unsigned RecStateLsb = 0;

  function automatic int unsigned rec_dur_lsb(input int unsigned nlamp);
    return 2 * nlamp;
  endfunction

  typedef enum logic {
    StInit,
    StTrack
  } lamp_fsm_e;

  function automatic logic [1:0] lamp_class(input logic seen0, input logic seen1);
    if (seen0 && seen1) return LAMP_FLICK;
    else if (seen1)     return LAMP_ON;
    else                return LAMP_DARK;
  endfunction

endpackage

// File: rtl/lamp_fifo.sv
// Synchronous record FIFO; a push into a full queue is accepted only alongside a pop.
module lamp_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW  = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [AddrW-1:0] next_ptr(input logic [AddrW-1:0] ptr);
    return (ptr == AddrW'(Depth - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  // Empty head reads as zero so rec_data is clean after reset.
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
    if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/lamp_decoder.sv
// Lamp-bus decoder: classifies each lamp per window, tracks phases and queues phase records.
module lamp_decoder
  import lamp_pkg::*;
#(
  parameter int unsigned NLAMP      = 10,
  parameter int unsigned TICK_DIV   = 32768,
  parameter int unsigned WIN_TICKS  = 512,
  parameter int unsigned DUR_W      = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NLAMP-1:0]         db,
  output logic [2*NLAMP-1:0]       cur_state,
  output logic                     cur_valid,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic [2*NLAMP+DUR_W-1:0] rec_data,
  output logic [15:0]              phase_cnt,
  output logic                     overflow
);

  localparam int unsigned TickW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned WinW   = (WIN_TICKS > 1) ? $clog2(WIN_TICKS) : 1;
  localparam int unsigned RecW   = 2 * NLAMP + DUR_W;
  localparam int unsigned DurLsb = rec_dur_lsb(NLAMP);

  logic [NLAMP-1:0]   db_meta_q, db_sync_q;
  logic [TickW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [WinW-1:0]    win_cnt_q, win_cnt_d;
  logic [NLAMP-1:0]   seen0_q, seen0_d, seen1_q, seen1_d;
  logic [2*NLAMP-1:0] cur_state_q, cur_state_d, new_vec;
  logic               cur_valid_q, cur_valid_d;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic [15:0]        phase_cnt_q, phase_cnt_d;
  logic               overflow_q, overflow_d;
  lamp_fsm_e          state_q, state_d;
  logic               tick, win_end, load_first, changed, keep;
  logic               pop, fifo_full, fifo_empty;
  logic [RecW-1:0]    push_data;

  // Tick and window timing.
  assign tick    = (tick_cnt_q == TickW'(TICK_DIV - 1));
  assign win_end = tick && (win_cnt_q == WinW'(WIN_TICKS - 1));

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    win_cnt_d  = win_cnt_q;
    if (tick) win_cnt_d = win_end ? '0 : win_cnt_q + 1'b1;
  end

  always_comb begin
    seen0_d = seen0_q;
    seen1_d = seen1_q;
    if (win_end) begin
      seen0_d = '0;
      seen1_d = '0;
    end else if (tick) begin
      seen0_d = seen0_q | ~db_sync_q;
      seen1_d = seen1_q | db_sync_q;
    end
  end

  // Window vector folds in the final tick's sample.
  always_comb begin
    new_vec = '0;
    for (int k = 0; k < NLAMP; k++) begin
      new_vec[2*k +: 2] = lamp_class(seen0_q[k] | ~db_sync_q[k], seen1_q[k] | db_sync_q[k]);
    end
  end

  // FSM: state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= StInit;
    else       state_q <= state_d;
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StInit:  if (win_end) state_d = StTrack;
      StTrack: state_d = StTrack;
      default: state_d = StInit;
    endcase
  end

  // FSM: decoded actions.
  always_comb begin
    load_first = 1'b0;
    changed    = 1'b0;
    keep       = 1'b0;
    if (win_end) begin
      unique case (state_q)
        StInit:  load_first = 1'b1;
        StTrack: begin
          changed = (new_vec != cur_state_q);
          keep    = !changed;
        end
        default: ;
      endcase
    end
  end

  assign pop = rec_valid && rec_ready;

  always_comb begin
    cur_state_d = cur_state_q;
    cur_valid_d = cur_valid_q;
    dur_d       = dur_q;
    phase_cnt_d = phase_cnt_q;
    overflow_d  = overflow_q;
    if (load_first) begin
      cur_state_d = new_vec;
      cur_valid_d = 1'b1;
      dur_d       = DUR_W'(1);
    end else if (changed) begin
      cur_state_d = new_vec;
      dur_d       = DUR_W'(1);
      phase_cnt_d = phase_cnt_q + 16'd1;
      if (fifo_full && !pop) overflow_d = 1'b1;
    end else if (keep && (dur_q != '1)) begin
      dur_d = dur_q + 1'b1;
    end
  end

  always_comb begin
    push_data = '0;
    push_data[RecStateLsb +: 2*NLAMP] = cur_state_q;
    push_data[DurLsb +: DUR_W]        = dur_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      db_meta_q   <= '0;
      db_sync_q   <= '0;
      tick_cnt_q  <= '0;
      win_cnt_q   <= '0;
      seen0_q     <= '0;
      seen1_q     <= '0;
      cur_state_q <= '0;
      cur_valid_q <= 1'b0;
      dur_q       <= '0;
      phase_cnt_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      db_meta_q   <= db;
      db_sync_q   <= db_meta_q;
      tick_cnt_q  <= tick_cnt_d;
      win_cnt_q   <= win_cnt_d;
      seen0_q     <= seen0_d;
      seen1_q     <= seen1_d;
      cur_state_q <= cur_state_d;
      cur_valid_q <= cur_valid_d;
      dur_q       <= dur_d;
      phase_cnt_q <= phase_cnt_d;
      overflow_q  <= overflow_d;
    end
  end

  lamp_fifo #(
    .Width (RecW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (changed),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (rec_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rec_valid = !fifo_empty;
  assign cur_state = cur_state_q;
  assign cur_valid = cur_valid_q;
  assign phase_cnt = phase_cnt_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_lamp_decoder.sv
// Randomized bench for lamp_decoder against a window-level behavioural model.
module tb_lamp_decoder;

  localparam int NL   = 10;
  localparam int TDIV = 4;
  localparam int WIN  = 8;
  localparam int DW   = 4;
  localparam int DEP  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NL-1:0]     db;
  logic [2*NL-1:0]   cur_state;
  logic              cur_valid;
  logic              rec_valid;
  logic              rec_ready;
  logic [2*NL+DW-1:0] rec_data;
  logic [15:0]       phase_cnt;
  logic              overflow;

  always #5 clk = ~clk;

  lamp_decoder #(
    .NLAMP      (NL),
    .TICK_DIV   (TDIV),
    .WIN_TICKS  (WIN),
    .DUR_W      (DW),
    .FIFO_DEPTH (DEP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .db        (db),
    .cur_state (cur_state),
    .cur_valid (cur_valid),
    .rec_valid (rec_valid),
    .rec_ready (rec_ready),
    .rec_data  (rec_data),
    .phase_cnt (phase_cnt),
    .overflow  (overflow)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Behavioural model state.
  logic [NL-1:0]       m_seen0, m_seen1;
  int                  m_tick;
  logic [2*NL-1:0]     m_cur;
  logic                m_valid;
  logic [DW-1:0]       m_dur;
  logic [15:0]         m_pcnt;
  logic                m_ovf;
  logic [2*NL+DW-1:0]  m_q[$];
  int                  cyc;
  logic [NL-1:0]       db_val;
  int                  ready_mode;

  localparam logic [NL-1:0] PatA  = 10'b0010110010;
  localparam logic [NL-1:0] PatA2 = 10'b0010010010;
  localparam logic [NL-1:0] PatB  = 10'b1001000101;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2*NL-1:0] classify(input logic [NL-1:0] s0, input logic [NL-1:0] s1);
    logic [2*NL-1:0] v;
    v = '0;
    for (int k = 0; k < NL; k++) begin
      if (s0[k] && s1[k]) v[2*k +: 2] = 2'd2;
      else if (s1[k])     v[2*k +: 2] = 2'd1;
      else                v[2*k +: 2] = 2'd0;
    end
    return v;
  endfunction

  task automatic model_reset();
    m_seen0 = '0;
    m_seen1 = '0;
    m_tick  = 0;
    m_cur   = '0;
    m_valid = 1'b0;
    m_dur   = '0;
    m_pcnt  = '0;
    m_ovf   = 1'b0;
    m_q.delete();
    cyc     = 0;
  endtask

  task automatic model_tick(input logic [NL-1:0] v);
    logic [2*NL-1:0] vec;
    m_seen0 = m_seen0 | ~v;
    m_seen1 = m_seen1 | v;
    m_tick++;
    if (m_tick == WIN) begin
      vec     = classify(m_seen0, m_seen1);
      m_seen0 = '0;
      m_seen1 = '0;
      m_tick  = 0;
      if (!m_valid) begin
        m_cur   = vec;
        m_valid = 1'b1;
        m_dur   = DW'(1);
      end else if (vec == m_cur) begin
        if (m_dur != {DW{1'b1}}) m_dur = m_dur + 1'b1;
      end else begin
        if (m_q.size() < DEP) m_q.push_back({m_dur, m_cur});
        else                  m_ovf = 1'b1;
        m_pcnt = m_pcnt + 16'd1;
        m_cur  = vec;
        m_dur  = DW'(1);
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("cur_state", 64'(cur_state), 64'(m_cur));
    check_eq("cur_valid", 64'(cur_valid), 64'(m_valid));
    check_eq("rec_valid", 64'(rec_valid), 64'(m_q.size() > 0));
    if (m_q.size() > 0) check_eq("rec_data", 64'(rec_data), 64'(m_q[0]));
    check_eq("phase_cnt", 64'(phase_cnt), 64'(m_pcnt));
    check_eq("overflow", 64'(overflow), 64'(m_ovf));
  endtask

  // One clock: called at a negedge, returns at the next negedge.
  task automatic cycle();
    logic popping;
    check_outputs();
    case (ready_mode)
      0:       rec_ready = 1'b0;
      1:       rec_ready = 1'($urandom_range(0, 1));
      default: rec_ready = 1'b1;
    endcase
    popping = rec_ready && (m_q.size() > 0);
    @(posedge clk);
    if (popping) void'(m_q.pop_front());
    cyc++;
    if (cyc % TDIV == 0) model_tick(db_val);
    @(negedge clk);
  endtask

  task automatic tick_step(input logic [NL-1:0] v);
    db     = v;
    db_val = v;
    repeat (TDIV) cycle();
  endtask

  // kind: 0 steady a, 1 a/b alternating every 2 ticks, else random per tick.
  task automatic run_window(input logic [NL-1:0] a, input logic [NL-1:0] b, input int kind);
    logic [NL-1:0] v;
    for (int t = 0; t < WIN; t++) begin
      case (kind)
        0:       v = a;
        1:       v = ((t / 2) % 2 == 1) ? b : a;
        default: v = NL'($urandom);
      endcase
      tick_step(v);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    rec_ready = 1'b0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    check_outputs();
    check_eq("rst_rec_data", 64'(rec_data), 64'd0);
  endtask

  initial begin
    logic [NL-1:0] pool [4];
    int            kind, pick;
    reset      = 1'b1;
    db         = '0;
    db_val     = '0;
    rec_ready  = 1'b0;
    ready_mode = 2;
    model_reset();
    do_reset();

    repeat (5) run_window(PatA, PatA, 0);
    repeat (3) run_window(PatA, PatA2, 1);
    repeat (3) run_window(PatA, PatA, 0);
    repeat (2) run_window(PatB, PatB, 0);
    repeat (20) run_window(PatA, PatA, 0);
    run_window(PatB, PatB, 0);

    ready_mode = 0;
    run_window(PatA, PatA, 0);
    run_window(PatB, PatB, 0);
    run_window(PatA, PatA, 0);
    run_window(PatB, PatB, 0);
    run_window(PatA, PatA, 0);
    ready_mode = 2;
    repeat (2) run_window(PatA, PatA, 0);

    pool[0] = PatA;
    pool[1] = PatB;
    pool[2] = NL'($urandom);
    pool[3] = NL'($urandom);
    ready_mode = 1;
    repeat (40) begin
      pick = $urandom_range(0, 3);
      kind = $urandom_range(0, 5);
      if (kind > 2) kind = 0;
      run_window(pool[pick], pool[(pick + 1) % 4], kind);
    end

    ready_mode = 2;
    repeat (2) run_window(PatA, PatA, 0);
    repeat (5) tick_step(PatB);
    do_reset();
    repeat (2) run_window(PatB, PatB, 0);
    check_outputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
